// File: rtl/spmmio_overlay_fill_arb_if.sv
// Bus bundle for spmmio_overlay_fill_arb: CPU slave port, overlay master port and
// fill-engine register port. Bit 0 is the MSB on every vector.
interface spmmio_overlay_fill_arb_if;
    logic [0:12] c_adr;
    logic        c_cs;
    logic [0:3]  c_sel;
    logic        c_we;
    logic [0:31] c_d;
    logic [0:31] c_q;
    logic        c_ack;

    logic [0:12] o_adr;
    logic        o_cs;
    logic [0:3]  o_sel;
    logic        o_we;
    logic [0:31] o_d;
    logic [0:31] o_q;
    logic        o_ack;

    logic [0:1]  r_adr;
    logic        r_cs;
    logic        r_we;
    logic [0:3]  r_sel;
    logic [0:31] r_d;
    logic [0:31] r_q;
    logic        r_ack;

    // slave: the arbiter's view; master: the surrounding system's view.
    modport slave (
        input  c_adr, c_cs, c_sel, c_we, c_d,
        output c_q, c_ack,
        output o_adr, o_cs, o_sel, o_we, o_d,
        input  o_q, o_ack,
        input  r_adr, r_cs, r_we, r_sel, r_d,
        output r_q, r_ack
    );

    modport master (
        output c_adr, c_cs, c_sel, c_we, c_d,
        input  c_q, c_ack,
        input  o_adr, o_cs, o_sel, o_we, o_d,
        output o_q, o_ack,
        output r_adr, r_cs, r_we, r_sel, r_d,
        input  r_q, r_ack
    );
endinterface

// File: rtl/spmmio_overlay_fill_arb.sv
// Overlay bus arbiter sharing one master port between CPU accesses and a
// memory-fill engine that writes a constant pattern over a wrapping 4K-word range.
module spmmio_overlay_fill_arb #(
    parameter int fill_max_run = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    spmmio_overlay_fill_arb_if.slave        bus,
    output logic                            irq
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [3:0] RUN_LIMIT = 4'(fill_max_run);
    localparam logic [3:0] RUN_SAT   = 4'hF;

    logic [1:0]  state_q,     state_d;
    logic [12:0] o_adr_q,     o_adr_d;
    logic        o_cs_q,      o_cs_d;
    logic [3:0]  o_sel_q,     o_sel_d;
    logic        o_we_q,      o_we_d;
    logic [31:0] o_d_q,       o_d_d;
    logic [31:0] c_rdata_q,   c_rdata_d;
    logic [11:0] start_q,     start_d;
    logic [12:0] count_q,     count_d;
    logic [31:0] fill_q,      fill_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        ie_q,        ie_d;
    logic [11:0] cur_addr_q,  cur_addr_d;
    logic [12:0] remaining_q, remaining_d;
    logic [3:0]  run_q,       run_d;
    logic        fill_live_q, fill_live_d;

    // Register port viewed little-endian: r_d_le[0] is CTRL bit31, r_be[0] is the low byte lane.
    logic [31:0] r_d_le;
    logic [3:0]  r_be;
    logic [31:0] r_mask;
    logic [31:0] rdata;
    logic        reg_wr, ctrl_wr, go_wr, abort_wr, done_clr, fill_pend;

    assign r_d_le   = bus.r_d;
    assign r_be     = bus.r_sel;
    assign r_mask   = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
    assign reg_wr   = bus.r_cs & bus.r_we;
    assign ctrl_wr  = reg_wr & (bus.r_adr == 2'd3) & r_be[0];
    assign go_wr    = ctrl_wr & r_d_le[0];
    assign abort_wr = ctrl_wr & r_d_le[1];
    assign done_clr = ctrl_wr & r_d_le[3];
    assign fill_pend = busy_q & ~abort_wr;

    always_comb begin
        rdata = '0;
        case (bus.r_adr)
            2'd0:    rdata = {20'b0, start_q};
            2'd1:    rdata = {19'b0, count_q};
            2'd2:    rdata = fill_q;
            default: rdata = {27'b0, ie_q, done_q, busy_q, 2'b00};
        endcase
    end

    assign bus.r_q   = rdata;
    assign bus.r_ack = bus.r_cs;
    assign bus.c_q   = c_rdata_q;
    assign bus.c_ack = (state_q == ST_RESP);
    assign bus.o_adr = o_adr_q;
    assign bus.o_cs  = o_cs_q;
    assign bus.o_sel = o_sel_q;
    assign bus.o_we  = o_we_q;
    assign bus.o_d   = o_d_q;
    assign irq       = done_q & ie_q;

    always_comb begin
        state_d     = state_q;
        o_adr_d     = o_adr_q;
        o_cs_d      = o_cs_q;
        o_sel_d     = o_sel_q;
        o_we_d      = o_we_q;
        o_d_d       = o_d_q;
        c_rdata_d   = c_rdata_q;
        start_d     = start_q;
        count_d     = count_q;
        fill_d      = fill_q;
        busy_d      = busy_q;
        done_d      = done_q;
        ie_d        = ie_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        run_d       = run_q;
        fill_live_d = fill_live_q;

        if (reg_wr && !busy_q) begin
            case (bus.r_adr)
                2'd0:    start_d = (start_q & ~r_mask[11:0]) | (r_d_le[11:0] & r_mask[11:0]);
                2'd1:    count_d = (count_q & ~r_mask[12:0]) | (r_d_le[12:0] & r_mask[12:0]);
                2'd2:    fill_d  = (fill_q & ~r_mask) | (r_d_le & r_mask);
                default: ;
            endcase
        end
        if (ctrl_wr) ie_d = r_d_le[4];
        if (done_clr) done_d = 1'b0;

        // Abort drops the run at once; an in-flight fill still finishes on the bus
        // but fill_live_q stops it from touching the counters.
        if (abort_wr && busy_q) begin
            busy_d      = 1'b0;
            fill_live_d = 1'b0;
        end
        if (go_wr && !busy_q && !abort_wr) begin
            cur_addr_d  = start_q;
            remaining_d = count_q;
            if (count_q == 13'd0) begin
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.c_cs && (!fill_pend || run_q >= RUN_LIMIT)) begin
                    state_d = ST_CPU;
                    o_cs_d  = 1'b1;
                    o_adr_d = bus.c_adr;
                    o_sel_d = bus.c_sel;
                    o_we_d  = bus.c_we;
                    o_d_d   = bus.c_d;
                    run_d   = 4'd0;
                end else if (fill_pend) begin
                    state_d     = ST_FILL;
                    o_cs_d      = 1'b1;
                    o_adr_d     = {1'b0, cur_addr_q};
                    o_sel_d     = 4'hF;
                    o_we_d      = 1'b1;
                    o_d_d       = fill_q;
                    fill_live_d = 1'b1;
                end
            end
            ST_CPU: begin
                if (bus.o_ack) begin
                    state_d   = ST_RESP;
                    o_cs_d    = 1'b0;
                    c_rdata_d = bus.o_q;
                end
            end
            ST_FILL: begin
                if (bus.o_ack) begin
                    state_d     = ST_IDLE;
                    o_cs_d      = 1'b0;
                    fill_live_d = 1'b0;
                    if (run_q != RUN_SAT) run_d = run_q + 4'd1;
                    if (fill_live_q && !abort_wr) begin
                        cur_addr_d  = cur_addr_q + 12'd1;
                        remaining_d = remaining_q - 13'd1;
                        if (remaining_q == 13'd1) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            o_adr_q     <= '0;
            o_cs_q      <= 1'b0;
            o_sel_q     <= '0;
            o_we_q      <= 1'b0;
            o_d_q       <= '0;
            c_rdata_q   <= '0;
            start_q     <= '0;
            count_q     <= '0;
            fill_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ie_q        <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            run_q       <= '0;
            fill_live_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_adr_q     <= o_adr_d;
            o_cs_q      <= o_cs_d;
            o_sel_q     <= o_sel_d;
            o_we_q      <= o_we_d;
            o_d_q       <= o_d_d;
            c_rdata_q   <= c_rdata_d;
            start_q     <= start_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ie_q        <= ie_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            run_q       <= run_d;
            fill_live_q <= fill_live_d;
        end
    end
endmodule

// File: tb/tb_spmmio_overlay_fill_arb.sv
// Self-checking bench: an overlay memory model logs every acknowledged bus cycle,
// which is compared against fill sequences and CPU accesses predicted by the bench.
module tb_spmmio_overlay_fill_arb;
    logic clk = 1'b0;
    logic reset;
    logic irq;

    always #5 clk = ~clk;

    spmmio_overlay_fill_arb_if bus ();

    spmmio_overlay_fill_arb #(.fill_max_run(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    typedef struct {
        logic [12:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] d;
    } txn_t;

    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_ack  = 0;
    int   ov_cyc = 0;
    int   wr_lat = 1;
    int   rd_lat = 1;
    txn_t log_q[$];
    logic [31:0] ov_mem  [8192];
    logic [31:0] ref_mem [4096];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Overlay model: acks after a per-direction latency, returns stored data.
    always @(negedge clk) begin
        if (bus.o_cs) begin
            ov_cyc++;
            bus.o_ack = (ov_cyc >= (bus.o_we ? wr_lat : rd_lat));
            bus.o_q   = bus.o_ack ? ov_mem[bus.o_adr] : 32'h0;
        end else begin
            ov_cyc    = 0;
            bus.o_ack = 1'b0;
            bus.o_q   = 32'h0;
        end
        if (bus.c_ack) n_ack++;
    end

    always @(posedge clk) begin
        txn_t t;
        if (!reset && bus.o_cs && bus.o_ack) begin
            t.adr = bus.o_adr;
            t.we  = bus.o_we;
            t.sel = bus.o_sel;
            t.d   = bus.o_d;
            log_q.push_back(t);
            if (t.we)
                for (int b = 0; b < 4; b++)
                    if (t.sel[b]) ov_mem[t.adr][8*b +: 8] = t.d[8*b +: 8];
        end
    end

    function automatic int count_fill(input int from);
        int n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (!log_q[i].adr[12]) n++;
        return n;
    endfunction

    function automatic int count_cpu(input int from);
        int n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].adr[12]) n++;
        return n;
    endfunction

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.r_cs  = 1'b1;
        bus.r_we  = 1'b1;
        bus.r_adr = a;
        bus.r_sel = 4'hF;
        bus.r_d   = d;
        @(negedge clk);
        bus.r_cs  = 1'b0;
        bus.r_we  = 1'b0;
    endtask

    // Call in the low clock phase; register reads are combinational.
    task automatic reg_rd(input logic [1:0] a, output logic [31:0] v);
        bus.r_cs  = 1'b1;
        bus.r_we  = 1'b0;
        bus.r_adr = a;
        bus.r_sel = 4'hF;
        #1;
        v = bus.r_q;
        bus.r_cs  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        v = 32'h4;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reg_rd(2'd3, v);
            if (!v[2]) break;
        end
        check({tag, "_busy_clear"}, v[2], 1'b0);
    endtask

    task automatic wait_fills(input int base, input int n, input string tag);
        for (int i = 0; i < 3000 && count_fill(base) < n; i++) @(negedge clk);
        check({tag, "_fills_reached"}, count_fill(base) >= n, 1'b1);
    endtask

    task automatic cpu_op(input logic [12:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] d, output logic [31:0] q, output int lat);
        @(negedge clk);
        bus.c_adr = a;
        bus.c_we  = we;
        bus.c_sel = sel;
        bus.c_d   = d;
        bus.c_cs  = 1'b1;
        lat = -1;
        q   = '0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clk);
            if (bus.c_ack) begin
                q   = bus.c_q;
                lat = i;
                break;
            end
        end
        bus.c_cs = 1'b0;
    endtask

    task automatic check_fill_run(input string tag, input int base, input int start,
                                  input int count, input logic [31:0] fill);
        txn_t f[$];
        for (int i = base; i < log_q.size(); i++)
            if (!log_q[i].adr[12]) f.push_back(log_q[i]);
        check({tag, "_count"}, f.size(), count);
        for (int j = 0; j < f.size() && j < count; j++) begin
            check({tag, "_adr"}, f[j].adr, 13'((start + j) % 4096));
            check({tag, "_wr"}, {f[j].we, f[j].sel, f[j].d}, {1'b1, 4'hF, fill});
        end
    endtask

    task automatic run_fill(input string tag, input int start, input int count,
                            input logic [31:0] fill);
        int base;
        logic [31:0] v;
        reg_wr(2'd0, 32'(start));
        reg_wr(2'd1, 32'(count));
        reg_wr(2'd2, fill);
        base = log_q.size();
        reg_wr(2'd3, 32'h1);
        wait_idle(tag);
        check_fill_run(tag, base, start, count, fill);
        reg_rd(2'd3, v);
        check({tag, "_done"}, v[3], 1'b1);
    endtask

    task automatic run_random_round(input int r);
        int start, count, base, ack0, nops;
        logic [31:0] fill;
        start = $urandom_range(0, 4095);
        count = $urandom_range(1, 24);
        fill  = $urandom;
        nops  = $urandom_range(0, 4);
        wr_lat = $urandom_range(1, 3);
        rd_lat = $urandom_range(1, 3);
        reg_wr(2'd0, 32'(start));
        reg_wr(2'd1, 32'(count));
        reg_wr(2'd2, fill);
        base = log_q.size();
        ack0 = n_ack;
        fork
            begin
                reg_wr(2'd3, 32'h1);
                wait_idle($sformatf("rnd%0d", r));
            end
            begin
                logic [12:0] a;
                logic        we;
                logic [3:0]  sel;
                logic [31:0] d, q;
                int          lat;
                for (int k = 0; k < nops; k++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    a   = 13'h1000 | 13'($urandom_range(0, 4095));
                    we  = 1'($urandom_range(0, 1));
                    sel = 4'($urandom_range(1, 15));
                    d   = $urandom;
                    cpu_op(a, we, sel, d, q, lat);
                    check("rnd_cpu_acked", lat > 0, 1'b1);
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (sel[b]) ref_mem[a[11:0]][8*b +: 8] = d[8*b +: 8];
                    end else begin
                        check("rnd_cpu_rdata", q, ref_mem[a[11:0]]);
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        check_fill_run($sformatf("rnd%0d", r), base, start, count, fill);
        check("rnd_cpu_issued", count_cpu(base), nops);
        check("rnd_cpu_acks", n_ack - ack0, nops);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, q;
        int          lat, base, ack0, k, n;
        logic        ok;

        for (int i = 0; i < 8192; i++) ov_mem[i] = $urandom;
        for (int i = 0; i < 4096; i++) ref_mem[i] = ov_mem[4096 + i];
        ref_mem[5] = 32'h0;
        ov_mem[5]  = 32'h12345678;

        reset = 1'b1;
        bus.c_cs = 1'b0; bus.c_adr = '0; bus.c_sel = '0; bus.c_we = 1'b0; bus.c_d = '0;
        bus.r_cs = 1'b0; bus.r_adr = '0; bus.r_sel = '0; bus.r_we = 1'b0; bus.r_d = '0;
        repeat (3) @(negedge clk);

        check("rst_o_cs", bus.o_cs, 1'b0);
        check("rst_o_bus", {bus.o_adr, bus.o_sel, bus.o_we, bus.o_d}, '0);
        check("rst_c_ack", bus.c_ack, 1'b0);
        check("rst_c_q", bus.c_q, 32'h0);
        check("rst_irq", irq, 1'b0);
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), v);
            check($sformatf("rst_reg%0d", a), v, 32'h0);
        end
        bus.r_cs = 1'b1;
        #1;
        check("r_ack_follows_cs", bus.r_ack, 1'b1);
        bus.r_cs = 1'b0;
        reset = 1'b0;

        // CPU write latency on an idle arbiter.
        wr_lat = 1;
        cpu_op(13'h0123, 1'b1, 4'hF, 32'hDEADBEEF, q, lat);
        check("cpu_wr_latency", lat, 2);
        @(negedge clk);
        check("c_ack_one_cycle", bus.c_ack, 1'b0);
        check("cpu_wr_bus", {log_q[log_q.size()-1].adr, log_q[log_q.size()-1].we,
                             log_q[log_q.size()-1].sel, log_q[log_q.size()-1].d},
              {13'h0123, 1'b1, 4'hF, 32'hDEADBEEF});

        // CPU read where the overlay acks one cycle late.
        rd_lat = 2;
        cpu_op(13'h0005, 1'b0, 4'hF, 32'h0, q, lat);
        check("cpu_rd_data", q, 32'h12345678);
        check("cpu_rd_latency", lat, 3);
        rd_lat = 1;

        run_fill("fill_basic", 12'h010, 3, 32'hA5A5A5A5);
        run_fill("fill_wrap", 12'hFFE, 4, 32'h0F1E2D3C);
        check("c_q_held", bus.c_q, 32'h12345678);

        reg_wr(2'd3, 32'h10);
        check("irq_set", irq, 1'b1);
        reg_wr(2'd3, 32'h18);
        check("irq_clear", irq, 1'b0);
        reg_rd(2'd3, v);
        check("done_w1c", v[4:2], 3'b100);

        // Zero-length fill completes immediately with no bus cycle.
        reg_wr(2'd1, 32'h0);
        base = log_q.size();
        reg_wr(2'd3, 32'h1);
        reg_rd(2'd3, v);
        check("count0_done_busy", v[3:2], 2'b10);
        repeat (5) @(negedge clk);
        check("count0_no_cycles", log_q.size() - base, 0);
        reg_wr(2'd3, 32'h8);

        // Abort part-way through a 10-word fill.
        wr_lat = 2;
        reg_wr(2'd0, 32'h300);
        reg_wr(2'd1, 32'd10);
        base = log_q.size();
        reg_wr(2'd3, 32'h1);
        wait_fills(base, 2, "abort");
        reg_wr(2'd3, 32'h2);
        repeat (20) @(negedge clk);
        n = count_fill(base);
        check("abort_writes_2_or_3", (n == 2) || (n == 3), 1'b1);
        reg_rd(2'd3, v);
        check("abort_done_busy", v[3:2], 2'b00);
        wr_lat = 1;

        // go and abort together while idle: nothing starts.
        reg_wr(2'd1, 32'd5);
        base = log_q.size();
        reg_wr(2'd3, 32'h3);
        repeat (10) @(negedge clk);
        reg_rd(2'd3, v);
        check("go_abort_idle", v[3:2], 2'b00);
        check("go_abort_no_cycles", log_q.size() - base, 0);

        // CPU request held during a fill gets one interleaved grant.
        reg_wr(2'd0, 32'h100);
        reg_wr(2'd1, 32'd6);
        reg_wr(2'd2, 32'h5A5A0001);
        base = log_q.size();
        ack0 = n_ack;
        reg_wr(2'd3, 32'h1);
        wait_fills(base, 1, "alt");
        cpu_op(13'h1020, 1'b1, 4'hF, 32'hCAFE0001, q, lat);
        check("alt_cpu_acked", lat > 0, 1'b1);
        wait_idle("alt");
        ref_mem[12'h020] = 32'hCAFE0001;
        k = -1;
        n = 0;
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i].adr == 13'h1020 && log_q[i].we) begin
                n++;
                k = i;
            end
        check("alt_one_cpu_write", n, 1);
        check("alt_one_c_ack", n_ack - ack0, 1);
        ok = 1'b0;
        if (k > base) ok = !log_q[k-1].adr[12];
        check("alt_fill_before_cpu", ok, 1'b1);
        ok = 1'b0;
        if (k >= 0 && k + 1 < log_q.size()) ok = !log_q[k+1].adr[12];
        check("alt_fill_after_cpu", ok, 1'b1);
        check_fill_run("alt", base, 12'h100, 6, 32'h5A5A0001);

        for (int r = 0; r < 8; r++) run_random_round(r);

        // Reset while a fill write is on the bus.
        wr_lat = 4;
        reg_wr(2'd0, 32'h200);
        reg_wr(2'd1, 32'd5);
        base = log_q.size();
        ack0 = n_ack;
        reg_wr(2'd3, 32'h11);
        for (int i = 0; i < 100 && !bus.o_cs; i++) @(negedge clk);
        check("rst_fill_ocs_seen", bus.o_cs, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_fill_o_cs", bus.o_cs, 1'b0);
        check("rst_fill_o_bus", {bus.o_adr, bus.o_sel, bus.o_we, bus.o_d}, '0);
        check("rst_fill_c_q", bus.c_q, 32'h0);
        check("rst_fill_irq", irq, 1'b0);
        for (int a = 0; a < 4; a++) begin
            reg_rd(2'(a), v);
            check($sformatf("rst_fill_reg%0d", a), v, 32'h0);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_fill_no_cycles", log_q.size() - base, 0);

        // Reset while a CPU read waits on the overlay: no c_ack.
        rd_lat = 4;
        bus.c_adr = 13'h1001; bus.c_we = 1'b0; bus.c_sel = 4'hF; bus.c_cs = 1'b1;
        for (int i = 0; i < 100 && !bus.o_cs; i++) @(negedge clk);
        check("rst_cpu_ocs_seen", bus.o_cs, 1'b1);
        reset = 1'b1;
        bus.c_cs = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_c_ack", n_ack - ack0, 0);
        check("rst_cpu_no_cycles", log_q.size() - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
